sample_latch_bank: RTL and testbench
====================================

SAMPLE_LATCH_BANK -- requirements
Module: sample_latch_bank

Interface
REQ-001 Parameter WIDTH, default 12: bits per channel sample, unsigned.
REQ-002 Parameter CHANNELS, default 4: number of independent sample channels.
REQ-003 Parameter DIVW, default 16: width of the interval counter and Period input.
REQ-004 clock  input  1: single clock; all state on its rising edge.
REQ-005 resetn  input  1: reset, asynchronous, active-low.
REQ-006 Enable  input  1: high runs latch intervals; low holds outputs idle.
REQ-007 Mode  input  2: 0 = sample, 1 = peak-hold, 2 = average, 3 = reserved (behaves as sample).
REQ-008 Period  input  DIVW: interval length in clock cycles; 0 is treated as 1.
REQ-009 Shift  input  $clog2(DIVW+1): right-shift applied to the average-mode sum.
REQ-010 NumberIn  input  CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 NumberOut  output  CHANNELS*WIDTH: registered latched results, same packing.
REQ-012 Valid  output  1: one-cycle pulse coincident with each NumberOut update.

Function
REQ-013 States: IDLE (Enable low) and RUN (Enable high); IDLE->RUN on Enable high, RUN->IDLE on Enable low.
REQ-014 In IDLE: interval counter and lane accumulators cleared, NumberOut held, Valid 0.
REQ-015 Period, Mode and Shift are captured into shadow registers on the first RUN cycle and at each interval end; mid-interval changes take effect next interval.
REQ-016 Every RUN cycle samples NumberIn into each lane; the counter counts 0..P-1 (P = shadow Period, min 1).
REQ-017 On the cycle with count == P-1: NumberOut loads the lane results including that cycle's sample, Valid = 1, counter wraps to 0, accumulators restart.
REQ-018 Sample mode: result = last sample of the interval.
REQ-019 Peak mode: result = maximum sample in the interval; ties keep the value.
REQ-020 Average mode: sum held in WIDTH+DIVW bits; result = sum >> Shift, saturated to 2^WIDTH-1.
REQ-021 P = 1: Valid is high every RUN cycle; NumberOut equals NumberIn delayed one cycle.
REQ-022 Enable falling on count == P-1 still completes that interval; falling earlier discards the partial interval with no Valid.
REQ-023 Channels are fully independent; all share one counter and a common Valid.

Reset
REQ-024 resetn low asynchronously forces NumberOut = 0, Valid = 0, counter = 0, accumulators = 0, state IDLE, shadows = 0.
REQ-025 After resetn release, the first Valid occurs P cycles after the first RUN cycle.

Structure
REQ-026 Shared package latch_pkg holds the Mode encodings (MODE_SAMPLE, MODE_PEAK, MODE_AVG) and default parameter constants.
REQ-027 Per-channel accumulate/peak/saturate logic is sub-module latch_lane, instantiated CHANNELS times by a generate loop; the counter, state and shadows stay in the top.

Verification (WIDTH=12, CHANNELS=2, DIVW=16)
REQ-028 Sample, Period=4, ch0 = 0,1,2,... from the first RUN cycle -> NumberOut ch0 = 3, 7, 11; Valid every 4th cycle.
REQ-029 Peak, Period=4, ch0 = 5,100,7,2 then 1,1,1,1 -> 100, then 1.
REQ-030 Average, Period=4, Shift=2, ch0 = 1,2,3,4 -> 2; ch1 = 4095 x4 with Shift=0 -> saturates to 4095.
REQ-031 Period=0, sample mode -> Valid high every cycle; NumberOut tracks NumberIn with 1-cycle lag.
REQ-032 resetn low at count 2 of a Period=4 interval -> NumberOut = 0 and Valid = 0 immediately; after release, first Valid 4 cycles after RUN resumes.
REQ-033 Period 4->2 at count 1 -> the current interval ends at count 3, subsequent Valid pulses are 2 cycles apart.

Source files
------------

// File: rtl/latch_pkg.sv
// Shared constants for the sample latch bank: mode encodings, default sizes and FSM states.
package latch_pkg;

  localparam int unsigned DEF_WIDTH    = 12;
  localparam int unsigned DEF_CHANNELS = 4;
  localparam int unsigned DEF_DIVW     = 16;

  localparam logic [1:0] MODE_SAMPLE = 2'd0;
  localparam logic [1:0] MODE_PEAK   = 2'd1;
  localparam logic [1:0] MODE_AVG    = 2'd2;

  typedef enum logic {StIdle, StRun} state_e;

endpackage

// File: rtl/latch_lane.sv
// One channel of the latch bank: accumulates an interval's samples and
// loads the sample/peak/saturated-average result at interval end.
module latch_lane
  import latch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIVW  = DEF_DIVW,
  parameter int unsigned SHW   = $clog2(DIVW + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             active,
  input  logic             start,
  input  logic             last,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shift,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned SUMW = WIDTH + DIVW;

  logic [SUMW-1:0]  acc_q, acc_d, sample_ext, scaled;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    sample_ext = {{DIVW{1'b0}}, sample};
    acc_d      = sample_ext;
    if (!start) begin
      case (mode)
        MODE_SAMPLE: acc_d = sample_ext;
        MODE_PEAK:   acc_d = (acc_q > sample_ext) ? acc_q : sample_ext;
        MODE_AVG:    acc_d = acc_q + sample_ext;
        default:     acc_d = sample_ext;
      endcase
    end
    scaled = acc_d >> shift;
    res_d  = acc_d[WIDTH-1:0];
    // Average clamps to full scale when the shifted sum no longer fits
    if (mode == MODE_AVG) begin
      res_d = (|scaled[SUMW-1:WIDTH]) ? '1 : scaled[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q  <= '0;
      result <= '0;
    end else begin
      if (!active || last) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
      if (active && last) begin
        result <= res_d;
      end
    end
  end

endmodule

// File: rtl/sample_latch_bank.sv
// Multi-channel sample latch: a shared interval counter drives per-channel
// lanes that publish one result per interval with a common Valid pulse.
module sample_latch_bank
  import latch_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned DIVW     = DEF_DIVW
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      Enable,
  input  logic [1:0]                Mode,
  input  logic [DIVW-1:0]           Period,
  input  logic [$clog2(DIVW+1)-1:0] Shift,
  input  logic [CHANNELS*WIDTH-1:0] NumberIn,
  output logic [CHANNELS*WIDTH-1:0] NumberOut,
  output logic                      Valid
);

  localparam int unsigned SHW = $clog2(DIVW + 1);

  state_e          state_q;
  logic [DIVW-1:0] count_q, period_q, eff_period, last_count;
  logic [1:0]      mode_q, eff_mode;
  logic [SHW-1:0]  shift_q, eff_shift;
  logic            entering, last, start;

  // The first RUN cycle must already obey the live settings it is capturing
  always_comb begin
    entering   = Enable && (state_q == StIdle);
    eff_period = entering ? Period : period_q;
    eff_mode   = entering ? Mode : mode_q;
    eff_shift  = entering ? Shift : shift_q;
    last_count = (eff_period == '0) ? '0 : eff_period - DIVW'(1);
    last       = Enable && (count_q == last_count);
    start      = (count_q == '0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      count_q  <= '0;
      period_q <= '0;
      mode_q   <= '0;
      shift_q  <= '0;
      Valid    <= 1'b0;
    end else if (!Enable) begin
      state_q <= StIdle;
      count_q <= '0;
      Valid   <= 1'b0;
    end else begin
      state_q <= StRun;
      Valid   <= last;
      count_q <= last ? '0 : count_q + DIVW'(1);
      if (entering || last) begin
        period_q <= Period;
        mode_q   <= Mode;
        shift_q  <= Shift;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    latch_lane #(
      .WIDTH (WIDTH),
      .DIVW  (DIVW),
      .SHW   (SHW)
    ) u_lane (
      .clock  (clock),
      .resetn (resetn),
      .active (Enable),
      .start  (start),
      .last   (last),
      .mode   (eff_mode),
      .shift  (eff_shift),
      .sample (NumberIn[k*WIDTH +: WIDTH]),
      .result (NumberOut[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_sample_latch_bank.sv
// Self-checking bench: interval-level reference model plus directed and random stimulus.
module tb_sample_latch_bank;

  localparam int W  = 12;
  localparam int C  = 2;
  localparam int D  = 16;
  localparam int SW = $clog2(D + 1);

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic           Enable = 1'b0;
  logic [1:0]     Mode = '0;
  logic [D-1:0]   Period = '0;
  logic [SW-1:0]  Shift = '0;
  logic [C*W-1:0] NumberIn = '0;
  logic [C*W-1:0] NumberOut;
  logic           Valid;

  sample_latch_bank #(
    .WIDTH    (W),
    .CHANNELS (C),
    .DIVW     (D)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .Enable    (Enable),
    .Mode      (Mode),
    .Period    (Period),
    .Shift     (Shift),
    .NumberIn  (NumberIn),
    .NumberOut (NumberOut),
    .Valid     (Valid)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ch(input int k);
    return int'(NumberOut[k*W +: W]);
  endfunction

  // Reference model: collect each interval's samples, reduce them at interval end
  bit m_run = 0;
  int m_cnt = 0, m_per = 0, m_mode = 0, m_shift = 0;
  int m_q0[$];
  int m_q1[$];
  int m_out[C];
  bit m_valid = 0;

  function automatic int reduce(input int q[$], input int mode, input int shift);
    longint s = 0;
    int     mx = 0;
    foreach (q[i]) begin
      s += q[i];
      if (q[i] > mx) mx = q[i];
    end
    case (mode)
      1: return mx;
      2: begin
        s = s >> shift;
        return (s > 4095) ? 4095 : int'(s);
      end
      default: return q[q.size()-1];
    endcase
  endfunction

  initial begin
    foreach (m_out[k]) m_out[k] = 0;
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        m_run = 0; m_cnt = 0; m_per = 0; m_mode = 0; m_shift = 0;
        m_q0.delete(); m_q1.delete();
        foreach (m_out[k]) m_out[k] = 0;
        m_valid = 0;
      end else if (!Enable) begin
        m_run = 0; m_cnt = 0;
        m_q0.delete(); m_q1.delete();
        m_valid = 0;
      end else begin
        if (!m_run) begin
          m_run = 1; m_cnt = 0;
          m_per = int'(Period); m_mode = int'(Mode); m_shift = int'(Shift);
        end
        m_q0.push_back(int'(NumberIn[0 +: W]));
        m_q1.push_back(int'(NumberIn[W +: W]));
        m_cnt++;
        if (m_cnt == ((m_per == 0) ? 1 : m_per)) begin
          m_out[0] = reduce(m_q0, m_mode, m_shift);
          m_out[1] = reduce(m_q1, m_mode, m_shift);
          m_valid = 1;
          m_cnt = 0;
          m_q0.delete(); m_q1.delete();
          m_per = int'(Period); m_mode = int'(Mode); m_shift = int'(Shift);
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  // Compare process: outputs are registered, so they are stable at every falling edge
  initial begin
    forever begin
      @(negedge clock);
      check("model_valid", int'(Valid), int'(m_valid));
      for (int k = 0; k < C; k++) check("model_out", ch(k), m_out[k]);
    end
  end

  task automatic cyc(input bit en, input int mode, input int per, input int sh,
                     input int a0, input int a1);
    Enable   = en;
    Mode     = mode[1:0];
    Period   = per[D-1:0];
    Shift    = sh[SW-1:0];
    NumberIn = {a1[W-1:0], a0[W-1:0]};
    @(negedge clock);
  endtask

  int pk[8] = '{5, 100, 7, 2, 1, 1, 1, 1};
  int per_r, mode_r, sh_r, a0, a1;

  initial begin
    @(negedge clock);
    @(negedge clock);
    check("reset_out0", ch(0), 0);
    check("reset_valid", int'(Valid), 0);
    resetn = 1'b1;

    // Sample mode, Period 4: ch0 counts up from the first RUN cycle
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 4, 0, i, 100 + i);
      if (i % 4 == 3) begin
        check("smp_out", ch(0), i);
        check("smp_valid", int'(Valid), 1);
      end else begin
        check("smp_gap", int'(Valid), 0);
      end
    end
    cyc(0, 0, 4, 0, 0, 0);
    check("idle_hold", ch(0), 11);
    check("idle_valid", int'(Valid), 0);

    // Peak mode
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 4, 0, pk[i], 0);
      if (i == 3) check("peak_100", ch(0), 100);
      if (i == 7) check("peak_1", ch(0), 1);
    end
    cyc(0, 0, 4, 0, 0, 0);

    // Average mode: shifted mean and saturation
    for (int i = 0; i < 4; i++) cyc(1, 2, 4, 2, i + 1, 4095);
    check("avg_shift2", ch(0), 2);
    check("avg_sat_s2", ch(1), 4095);
    cyc(0, 0, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 2, 4, 0, i + 1, 4095);
    check("avg_sum", ch(0), 10);
    check("avg_sat", ch(1), 4095);
    cyc(0, 0, 4, 0, 0, 0);

    // Period 0 acts as 1: every cycle publishes
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0, 50 + i, 60 + i);
      check("p0_valid", int'(Valid), 1);
      check("p0_out", ch(0), 50 + i);
    end
    cyc(0, 0, 4, 0, 0, 0);

    // Asynchronous reset mid-interval (counter at 2)
    cyc(1, 0, 4, 0, 7, 8);
    cyc(1, 0, 4, 0, 9, 9);
    Enable = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("arst_out", ch(0), 0);
    check("arst_valid", int'(Valid), 0);
    @(negedge clock);
    #2 resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 4, 0, 20 + i, 0);
      check("post_rst_valid", int'(Valid), (i == 3) ? 1 : 0);
    end
    check("post_rst_out", ch(0), 23);
    cyc(0, 0, 4, 0, 0, 0);

    // Period 4 -> 2 at count 1: change lands at the next interval
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, (i == 0) ? 4 : 2, 0, i + 1, 0);
      check("per_chg_valid", int'(Valid), (i == 3 || i == 5 || i == 7) ? 1 : 0);
    end
    cyc(0, 0, 4, 0, 0, 0);

    // Random stimulus against the model
    per_r = 3; mode_r = 0; sh_r = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) per_r = int'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) mode_r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sh_r = int'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 5) == 0) ? 4095 : int'($urandom_range(0, 4095));
      a1 = int'($urandom_range(0, 4095));
      cyc($urandom_range(0, 19) != 0, mode_r, per_r, sh_r, a0, a1);
    end
    cyc(0, 0, 4, 0, 0, 0);
    cyc(0, 0, 4, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
